// File: rtl/send_pkg.sv
// rtl/send_pkg.sv - shared frame-link state encoding and field constants
// S_IFG and IFG_LEN exist only when SEND_TOP_IFG_EN is defined.
package send_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PREAMBLE = 4'd1,
    S_SFD      = 4'd2,
    S_MACDST   = 4'd3,
    S_MACSRC   = 4'd4,
    S_PLLEN    = 4'd5,
    S_PL       = 4'd6,
    S_FCS      = 4'd7
`ifdef SEND_TOP_IFG_EN
    , S_IFG    = 4'd8
`endif
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0]  SFD_BYTE      = 8'hAB;
  localparam logic [15:0] PREAMBLE_LEN  = 16'd7;
  localparam logic [15:0] MAC_LEN       = 16'd6;
  localparam logic [15:0] PLLEN_LEN     = 16'd2;
  localparam logic [15:0] FCS_LEN       = 16'd4;
`ifdef SEND_TOP_IFG_EN
  localparam logic [15:0] IFG_LEN       = 16'd12;
`endif

  // Addresses go out least-significant byte first.
  function automatic logic [7:0] mac_byte(input logic [47:0] addr, input logic [2:0] idx);
    return 8'(addr >> {idx, 3'b000});
  endfunction

  function automatic logic [7:0] fcs_byte(input logic [7:0] sum);
    return 8'(~sum + 8'd1);
  endfunction

endpackage

// File: rtl/send_fifo.sv
// rtl/send_fifo.sv - synchronous byte FIFO for the transmitter payload
// Combinational read of the head entry; rd_i pops it on the clock edge.
module send_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              wr_data_i,
  input  logic                    wr_vld_i,
  output logic                    wr_rdy_o,
  input  logic                    rd_i,
  output logic [7:0]              rd_data_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          wr_rdy_q;
  logic          wr_en;

  assign wr_en     = wr_vld_i && wr_rdy_q;
  assign wr_rdy_o  = wr_rdy_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_i) begin
      count_d = count_q + CNT_ONE;
    end else if (!wr_en && rd_i) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_rdy_q <= 1'b1;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      wr_rdy_q <= (count_d != CNT_FULL);
    end
  end

endmodule

// File: rtl/send_top.sv
// rtl/send_top.sv - byte-serial frame transmitter with payload FIFO and LRC check field
// Define SEND_TOP_IFG_EN to insert a 12-cycle inter-frame gap after each frame.
module send_top
  import send_pkg::*;
#(
  parameter logic [47:0] SRC_MAC_ADDR = 48'h000a959d6820,
  parameter int          FIFO_DEPTH   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pl_data,
  input  logic        pl_vld,
  output logic        pl_ready,
  input  logic        start,
  input  logic [15:0] len,
  input  logic [47:0] dst_mac,
  output logic        ready,
  output logic        reject,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  output logic        tx_start,
  output logic        done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state_q;
  logic [15:0]   cnt_q;
  logic [15:0]   len_q;
  logic [47:0]   dst_q;
  logic [7:0]    sum_q;
  logic          ready_q, reject_q, tx_vld_q, tx_start_q, done_q;
  logic [7:0]    tx_data_q;

  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_rd_data;
  logic          fifo_pop;
  logic          accept;
  logic          last_pl;

  send_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_data_i (pl_data),
    .wr_vld_i  (pl_vld),
    .wr_rdy_o  (pl_ready),
    .rd_i      (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .count_o   (fifo_count)
  );

  assign accept  = start && ready_q && (len != 16'd0) && ({1'b0, len} <= 17'(fifo_count));
  assign last_pl = (cnt_q == len_q - 16'd1);
  // Pop on every edge that puts a payload byte on tx_data.
  assign fifo_pop = ((state_q == S_PLLEN) && (cnt_q == PLLEN_LEN - 16'd1)) ||
                    ((state_q == S_PL) && !last_pl);

  assign ready    = ready_q;
  assign reject   = reject_q;
  assign tx_data  = tx_data_q;
  assign tx_vld   = tx_vld_q;
  assign tx_start = tx_start_q;
  assign done     = done_q;

  // state_q/cnt_q name the byte currently on tx_data; each edge chooses the next one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      dst_q      <= '0;
      sum_q      <= '0;
      ready_q    <= 1'b1;
      reject_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      reject_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q   <= 1'b1;
          tx_vld_q  <= 1'b0;
          tx_data_q <= '0;
          if (accept) begin
            state_q    <= S_PREAMBLE;
            cnt_q      <= '0;
            len_q      <= len;
            dst_q      <= dst_mac;
            sum_q      <= '0;
            ready_q    <= 1'b0;
            tx_vld_q   <= 1'b1;
            tx_data_q  <= PREAMBLE_BYTE;
            tx_start_q <= 1'b1;
          end else if (start && ready_q) begin
            reject_q <= 1'b1;
          end
        end
        S_PREAMBLE: begin
          if (cnt_q == PREAMBLE_LEN - 16'd1) begin
            state_q   <= S_SFD;
            cnt_q     <= '0;
            tx_data_q <= SFD_BYTE;
          end else begin
            cnt_q     <= cnt_q + 16'd1;
            tx_data_q <= PREAMBLE_BYTE;
          end
        end
        S_SFD: begin
          state_q   <= S_MACDST;
          cnt_q     <= '0;
          tx_data_q <= mac_byte(dst_q, 3'd0);
          sum_q     <= sum_q + mac_byte(dst_q, 3'd0);
        end
        S_MACDST: begin
          if (cnt_q == MAC_LEN - 16'd1) begin
            state_q   <= S_MACSRC;
            cnt_q     <= '0;
            tx_data_q <= mac_byte(SRC_MAC_ADDR, 3'd0);
            sum_q     <= sum_q + mac_byte(SRC_MAC_ADDR, 3'd0);
          end else begin
            cnt_q     <= cnt_q + 16'd1;
            tx_data_q <= mac_byte(dst_q, 3'(cnt_q + 16'd1));
            sum_q     <= sum_q + mac_byte(dst_q, 3'(cnt_q + 16'd1));
          end
        end
        S_MACSRC: begin
          if (cnt_q == MAC_LEN - 16'd1) begin
            state_q   <= S_PLLEN;
            cnt_q     <= '0;
            tx_data_q <= len_q[7:0];
            sum_q     <= sum_q + len_q[7:0];
          end else begin
            cnt_q     <= cnt_q + 16'd1;
            tx_data_q <= mac_byte(SRC_MAC_ADDR, 3'(cnt_q + 16'd1));
            sum_q     <= sum_q + mac_byte(SRC_MAC_ADDR, 3'(cnt_q + 16'd1));
          end
        end
        S_PLLEN: begin
          if (cnt_q == PLLEN_LEN - 16'd1) begin
            state_q   <= S_PL;
            cnt_q     <= '0;
            tx_data_q <= fifo_rd_data;
            sum_q     <= sum_q + fifo_rd_data;
          end else begin
            cnt_q     <= cnt_q + 16'd1;
            tx_data_q <= len_q[15:8];
            sum_q     <= sum_q + len_q[15:8];
          end
        end
        S_PL: begin
          if (last_pl) begin
            state_q   <= S_FCS;
            cnt_q     <= '0;
            tx_data_q <= fcs_byte(sum_q);
          end else begin
            cnt_q     <= cnt_q + 16'd1;
            tx_data_q <= fifo_rd_data;
            sum_q     <= sum_q + fifo_rd_data;
          end
        end
        S_FCS: begin
          if (cnt_q == FCS_LEN - 16'd1) begin
            cnt_q     <= '0;
            tx_vld_q  <= 1'b0;
            tx_data_q <= '0;
`ifdef SEND_TOP_IFG_EN
            state_q   <= S_IFG;
`else
            state_q   <= S_IDLE;
            ready_q   <= 1'b1;
`endif
          end else begin
            cnt_q  <= cnt_q + 16'd1;
            done_q <= (cnt_q == FCS_LEN - 16'd2);
          end
        end
`ifdef SEND_TOP_IFG_EN
        S_IFG: begin
          if (cnt_q == IFG_LEN - 16'd1) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`endif
        default: begin
          state_q   <= S_IDLE;
          cnt_q     <= '0;
          ready_q   <= 1'b1;
          tx_vld_q  <= 1'b0;
          tx_data_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_send_top.sv
// tb/tb_send_top.sv - randomized bench for send_top against a frame-level reference model
// Define SEND_TOP_IFG_EN for both bench and RTL to cover the inter-frame gap build.
module tb_send_top;

  localparam logic [47:0] SRC_MAC = 48'h000a959d6820;
  localparam int DEPTH = 64;
`ifdef SEND_TOP_IFG_EN
  localparam int GAP = 12;
`else
  localparam int GAP = 0;
`endif

  logic        clk, rst;
  logic [7:0]  pl_data;
  logic        pl_vld, pl_ready;
  logic        start;
  logic [15:0] len;
  logic [47:0] dst_mac;
  logic        ready, reject;
  logic [7:0]  tx_data;
  logic        tx_vld, tx_start, done;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl_fifo[$];
  logic [7:0] exp_q[$];
  int cnt_model = 0;

  send_top #(.SRC_MAC_ADDR(SRC_MAC), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .pl_data  (pl_data),
    .pl_vld   (pl_vld),
    .pl_ready (pl_ready),
    .start    (start),
    .len      (len),
    .dst_mac  (dst_mac),
    .ready    (ready),
    .reject   (reject),
    .tx_data  (tx_data),
    .tx_vld   (tx_vld),
    .tx_start (tx_start),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the model FIFO follows the write handshake seen at the edge.
  task automatic tick();
    logic wr;
    wr = pl_vld && pl_ready;
    @(posedge clk);
    if (!rst) begin
      mdl_fifo.delete();
      cnt_model = 0;
    end else if (wr) begin
      mdl_fifo.push_back(pl_data);
      cnt_model++;
    end
    #1;
    if (pl_vld) pl_data = 8'($urandom);
  endtask

  task automatic write_bytes(input int n);
    pl_vld  = 1'b1;
    pl_data = 8'($urandom);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("pl_ready_fill", pl_ready, cnt_model != DEPTH);
    end
    pl_vld = 1'b0;
  endtask

  task automatic build_frame(input logic [47:0] d, input logic [15:0] l);
    logic [47:0] src;
    int sum;
    src = SRC_MAC;
    exp_q.delete();
    for (int k = 0; k < 7; k++) exp_q.push_back(8'hAA);
    exp_q.push_back(8'hAB);
    for (int k = 0; k < 6; k++) exp_q.push_back(d[8*k +: 8]);
    for (int k = 0; k < 6; k++) exp_q.push_back(src[8*k +: 8]);
    exp_q.push_back(l[7:0]);
    exp_q.push_back(l[15:8]);
    for (int k = 0; k < int'(l); k++) exp_q.push_back(mdl_fifo.pop_front());
    sum = 0;
    for (int k = 8; k < exp_q.size(); k++) sum += int'(exp_q[k]);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'((256 - (sum % 256)) % 256));
  endtask

  task automatic request(input logic [47:0] d, input logic [15:0] l);
    bit acc;
    acc = (l != 16'd0) && (int'(l) <= cnt_model);
    start   = 1'b1;
    len     = l;
    dst_mac = d;
    tick();
    start = 1'b0;
    chk("tx_start_on_accept", tx_start, acc);
    chk("reject_pulse", reject, !acc);
    chk("ready_after_start", ready, !acc);
    if (acc) build_frame(d, l);
    else chk("tx_vld_after_reject", tx_vld, 1'b0);
  endtask

  // Starts on the tx_start cycle; leaves the bench on the done cycle (or abort_at).
  task automatic capture(input int abort_at);
    int n, l;
    n = exp_q.size();
    l = n - 26;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      if (i >= 22 && i < 22 + l) cnt_model--;
      chk($sformatf("tx_data[%0d]", i), tx_data, exp_q[i]);
      chk($sformatf("tx_vld[%0d]", i), tx_vld, 1'b1);
      chk("tx_start_pos", tx_start, i == 0);
      chk("done_pos", done, i == n - 1);
      chk("ready_busy", ready, 1'b0);
      chk("pl_ready_frame", pl_ready, cnt_model != DEPTH);
      if (i == abort_at) return;
    end
  endtask

  task automatic finish_frame();
    for (int k = 1; k <= GAP + 1; k++) begin
      tick();
      chk("post_vld", tx_vld, 1'b0);
      chk("post_data", tx_data, 8'h00);
      chk("post_done", done, 1'b0);
      chk("post_ready", ready, k > GAP);
    end
  endtask

  function automatic logic [47:0] rand_mac();
    return {16'($urandom), 32'($urandom)};
  endfunction

  initial begin
    int n, k;
    bit found;
    logic [47:0] d2;

    rst = 1'b0; pl_data = '0; pl_vld = 1'b0; start = 1'b0; len = '0; dst_mac = '0;
    tick();
    tick();
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_vld", tx_vld, 1'b0);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_reject", reject, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_pl_ready", pl_ready, 1'b1);
    rst = 1'b1;
    tick();

    // Single-byte frame with a known check field.
    pl_vld = 1'b1; pl_data = 8'h05;
    tick();
    pl_vld = 1'b0;
    request(48'h000a959d6816, 16'd1);
    capture(-1);
    chk("single_fcs", tx_data, 8'h7C);
    finish_frame();

    // Short FIFO and zero length are refused without disturbing the FIFO.
    write_bytes(3);
    request(rand_mac(), 16'd4);
    tick();
    chk("reject_one_cycle", reject, 1'b0);
    chk("short_vld", tx_vld, 1'b0);
    chk("short_ready", ready, 1'b1);
    request(rand_mac(), 16'd0);
    request(rand_mac(), 16'd3);
    capture(-1);
    finish_frame();

    // Full FIFO, with writes held on through the frame.
    write_bytes(DEPTH);
    chk("pl_ready_full", pl_ready, 1'b0);
    pl_vld = 1'b1;
    tick();
    request(rand_mac(), 16'(DEPTH));
    capture(-1);
    pl_vld = 1'b0;
    finish_frame();
    request(rand_mac(), 16'(cnt_model));
    capture(-1);
    finish_frame();

    // Random lengths, interleaved with over-length requests.
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 20);
      write_bytes(n + $urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) begin
        request(rand_mac(), 16'(cnt_model + 1));
        tick();
      end
      request(rand_mac(), 16'(n));
      capture(-1);
      finish_frame();
    end

    // Reset during the third payload byte.
    write_bytes(8);
    request(rand_mac(), 16'd8);
    capture(24);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_tx_vld", tx_vld, 1'b0);
    chk("midrst_tx_data", tx_data, 8'h00);
    chk("midrst_tx_start", tx_start, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_reject", reject, 1'b0);
    chk("midrst_ready", ready, 1'b1);
    chk("midrst_pl_ready", pl_ready, 1'b1);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("midrst_no_done", done, 1'b0);
      chk("midrst_idle_vld", tx_vld, 1'b0);
    end
    request(rand_mac(), 16'd1);

    // Back-to-back frames, second start in the done+1 cycle.
    tick();
    write_bytes(4);
    request(rand_mac(), 16'd2);
    capture(-1);
    tick();
    k = 1;
    d2 = rand_mac();
    start = 1'b1; len = 16'd2; dst_mac = d2;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      chk("b2b_ready", ready, k > GAP);
      tick();
      k++;
      if (tx_start) found = 1'b1;
      else chk("b2b_gap_vld", tx_vld, 1'b0);
    end
    start = 1'b0;
    chk("b2b_found", found, 1'b1);
    chk("b2b_latency", k, GAP + 2);
    if (found) begin
      build_frame(d2, 16'd2);
      capture(-1);
      finish_frame();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
